// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block: ALU-control decode, 32-bit ALU with zero/overflow
// flags, and an independent branch-target adder, all registered with one-cycle latency.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic             out_valid,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] add_y
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  logic [3:0]       ctrl_next;
  logic [WIDTH-1:0] result_next;
  logic             overflow_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    ctrl_next = CTRL_BAD;
    unique case (alu_op)
      2'b00:   ctrl_next = CTRL_ADD;
      2'b01:   ctrl_next = CTRL_SUB;
      2'b11:   ctrl_next = CTRL_ADD;
      default: begin
        case (funct)
          6'b100000: ctrl_next = CTRL_ADD;
          6'b100010: ctrl_next = CTRL_SUB;
          6'b100100: ctrl_next = CTRL_AND;
          6'b100101: ctrl_next = CTRL_OR;
          6'b101010: ctrl_next = CTRL_SLT;
          6'b100111: ctrl_next = CTRL_NOR;
          default:   ctrl_next = CTRL_BAD;
        endcase
      end
    endcase
  end

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // Overflow is only meaningful for ADD/SUB; every other code forces it low.
  always_comb begin
    result_next   = '0;
    overflow_next = 1'b0;
    case (ctrl_next)
      CTRL_AND: result_next = op_a & op_b;
      CTRL_OR:  result_next = op_a | op_b;
      CTRL_NOR: result_next = ~(op_a | op_b);
      CTRL_ADD: begin
        result_next   = sum;
        overflow_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      CTRL_SUB: begin
        result_next   = diff;
        overflow_next = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                        (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      CTRL_SLT: result_next = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default:  result_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_ctrl   <= '0;
      alu_result <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      add_y      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_ctrl   <= ctrl_next;
        alu_result <= result_next;
        zero       <= (result_next == '0);
        overflow   <= overflow_next;
        add_y      <= add_a + add_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected outputs are queued as stimulus is
// driven and compared one cycle later, after the capturing edge.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, add_a, add_b;
  logic        out_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic [31:0] add_y;

  typedef struct {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] y;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b),
    .out_valid(out_valid), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .zero(zero), .overflow(overflow), .add_y(add_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] modelCtrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 4'b0110;
    if (op != 2'b10) return 4'b0010;
    case (f)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      6'h27:   return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // Reference ALU built on 64-bit signed arithmetic so overflow is an explicit range test.
  task automatic modelAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic ov);
    longint sa, sbv, wide;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r = 32'h0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin wide = sa + sbv; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b0110: begin wide = sa - sbv; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      4'b0111: r = (sa < sbv) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endtask

  task automatic compareFront();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput({e.tag, ".valid"},    {31'd0, out_valid}, {31'd0, e.v});
    checkOutput({e.tag, ".ctrl"},     {28'd0, alu_ctrl},  {28'd0, e.ctrl});
    checkOutput({e.tag, ".result"},   alu_result,         e.res);
    checkOutput({e.tag, ".zero"},     {31'd0, zero},      {31'd0, e.z});
    checkOutput({e.tag, ".overflow"}, {31'd0, overflow},  {31'd0, e.ov});
    checkOutput({e.tag, ".add_y"},    add_y,              e.y);
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] op,
                               input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] aa, input logic [31:0] ab, input string tag);
    exp_t e;
    logic [31:0] r;
    logic ov;
    @(negedge clk);
    reset = rst; in_valid = v; alu_op = op; funct = f;
    op_a = a; op_b = b; add_a = aa; add_b = ab;
    if (rst) begin
      e = '{v: 1'b0, ctrl: 4'h0, res: 32'h0, z: 1'b0, ov: 1'b0, y: 32'h0, tag: tag};
    end else if (v) begin
      e.v = 1'b1;
      e.ctrl = modelCtrl(op, f);
      modelAlu(e.ctrl, a, b, r, ov);
      e.res = r;
      e.z = (r == 32'h0);
      e.ov = ov;
      e.y = aa + ab;
      e.tag = tag;
    end else begin
      e = last;
      e.v = 1'b0;
      e.tag = tag;
    end
    last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compareFront();
  endtask

  initial begin
    logic [5:0] functs [6];
    logic [5:0] fsel;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'h0;
    op_a = '0; op_b = '0; add_a = '0; add_b = '0;
    last = '{v: 1'b0, ctrl: 4'h0, res: 32'h0, z: 1'b0, ov: 1'b0, y: 32'h0, tag: ""};

    applyStimulus(1, 0, 2'b00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, "reset0");
    applyStimulus(1, 0, 2'b00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, "reset1");
    applyStimulus(0, 0, 2'b10, 6'h20, 32'h9, 32'h9, 32'h1, 32'h1, "idle_after_reset");

    applyStimulus(0, 1, 2'b10, 6'h20, 32'd5, 32'd7, 32'h0, 32'h0, "add_5_7");
    applyStimulus(0, 1, 2'b01, 6'h00, 32'h1234, 32'h1234, 32'h0, 32'h0, "beq_equal");
    applyStimulus(0, 1, 2'b01, 6'h00, 32'h80000000, 32'h1, 32'h0, 32'h0, "sub_overflow");
    applyStimulus(0, 1, 2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, "add_overflow");
    applyStimulus(0, 1, 2'b11, 6'h22, 32'h10, 32'h3, 32'h0, 32'h0, "aluop11_add");
    applyStimulus(0, 1, 2'b10, 6'h2A, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, "slt_neg_lt");
    applyStimulus(0, 1, 2'b10, 6'h2A, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, "slt_pos_ge");
    applyStimulus(0, 1, 2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, "and");
    applyStimulus(0, 1, 2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, "or");
    applyStimulus(0, 1, 2'b10, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, "nor");
    applyStimulus(0, 1, 2'b10, 6'h3F, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h0, "invalid_funct");
    applyStimulus(0, 1, 2'b00, 6'h00, 32'h1, 32'h2, 32'h00400000, 32'h10, "adder_pc");
    applyStimulus(0, 1, 2'b00, 6'h00, 32'h1, 32'h2, 32'hFFFFFFFC, 32'h8, "adder_wrap");
    applyStimulus(0, 0, 2'b10, 6'h24, 32'h0, 32'h0, 32'h5, 32'h5, "hold_invalid");

    for (int i = 0; i < 20; i++) begin
      fsel = functs[$urandom_range(5, 0)];
      applyStimulus(0, 1, 2'b10, fsel, $urandom, $urandom, $urandom, $urandom, $sformatf("rand%0d", i));
    end

    applyStimulus(1, 1, 2'b10, 6'h20, 32'd5, 32'd7, 32'h1, 32'h1, "reset_priority");
    applyStimulus(0, 1, 2'b10, 6'h22, 32'd3, 32'd3, 32'h4, 32'h4, "after_reset_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
